rr_grant_ctrl: RTL and testbench

//  Round-robin arbiter that shares one resource among NUM_ENTRY requesters.

---
 rtl/rr_grant_ctrl.sv | 177 +++++++++++++++++
 tb/tb_rr_grant_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin arbiter with a registered one-hot grant,
// hold-limit forced release and a one-cycle turnaround bubble.

// One-hot to binary encoder; the result is exact only for one-hot
// or all-zero input, which the arbiter guarantees for its grant.
module rr_onehot_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_onehot,
    output logic [W-1:0] o_bin
);

    // OR together the indices of every set bit
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < N; i++) begin
            if (i_onehot[i]) begin
                o_bin = o_bin | W'(i);
            end
        end
    end

endmodule

module rr_grant_ctrl #(
    parameter int NUM_ENTRY = 8,
    parameter int MAX_HOLD  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_ENTRY-1:0]         I_Req,
    input  logic [NUM_ENTRY-1:0]         I_Release,
    output logic [NUM_ENTRY-1:0]         O_Grant,
    output logic [$clog2(NUM_ENTRY)-1:0] O_GrantNo,
    output logic                         O_Valid,
    output logic                         O_Timeout
);

    localparam int IW = $clog2(NUM_ENTRY);
    localparam int PW = IW + 1;
    localparam int HW = $clog2(MAX_HOLD);

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_ENTRY - 1);
    localparam logic [PW-1:0] N_WIDE    = PW'(NUM_ENTRY);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    if (NUM_ENTRY < 2) begin : g_bad_num_entry
        $error("rr_grant_ctrl: NUM_ENTRY must be >= 2");
    end

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("rr_grant_ctrl: MAX_HOLD must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TURN
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        ptr_d;
    logic [HW-1:0]        hold_cnt_q;
    logic [HW-1:0]        hold_cnt_d;
    logic [NUM_ENTRY-1:0] grant_q;
    logic [NUM_ENTRY-1:0] grant_d;
    logic                 timeout_q;
    logic                 timeout_d;

    logic [NUM_ENTRY-1:0] winner;
    logic                 arb_found;
    logic [PW-1:0]        arb_pos;
    logic [IW-1:0]        grant_idx;
    logic                 own_req;
    logic                 own_rel;
    logic                 hold_end;
    logic                 exit_grant;

    // binary index of the registered grant
    rr_onehot_enc #(
        .N (NUM_ENTRY),
        .W (IW)
    ) u_enc (
        .i_onehot (grant_q),
        .o_bin    (grant_idx)
    );

    // rotating-priority search: first request at ptr, ptr+1, ... with wrap
    always_comb begin
        winner    = '0;
        arb_found = 1'b0;
        arb_pos   = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            arb_pos = {1'b0, ptr_q} + PW'(i);
            if (arb_pos >= N_WIDE) begin
                arb_pos = arb_pos - N_WIDE;
            end
            if (!arb_found && I_Req[arb_pos[IW-1:0]]) begin
                winner[arb_pos[IW-1:0]] = 1'b1;
                arb_found               = 1'b1;
            end
        end
    end

    // owner's request/release are picked out by masking with the grant
    always_comb begin
        own_req    = |(I_Req & grant_q);
        own_rel    = |(I_Release & grant_q);
        hold_end   = (hold_cnt_q == HOLD_LAST);
        exit_grant = own_rel || !own_req || hold_end;
    end

    // next-state, pointer rotation, hold counting and timeout flag
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|I_Req) begin
                    state_d    = ST_GRANT;
                    grant_d    = winner;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (exit_grant) begin
                    state_d    = ST_TURN;
                    grant_d    = '0;
                    hold_cnt_d = '0;
                    ptr_d      = (grant_idx == LAST_IDX) ?
                                 '0 : grant_idx + IW'(1);
                    timeout_d  = hold_end && own_req && !own_rel;
                end else if (!hold_end) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // state registers; reset drops any grant at once with no timeout
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            timeout_q  <= timeout_d;
        end
    end

    assign O_Grant   = grant_q;
    assign O_GrantNo = grant_idx;
    assign O_Valid   = |grant_q;
    assign O_Timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: directed table, corner sequences and random
// stimulus against a behavioural arbiter model, on 8- and 5-entry DUTs.
module tb_rr_grant_ctrl;

    localparam int N8 = 8;
    localparam int H8 = 16;
    localparam int N5 = 5;
    localparam int H5 = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req8  = '0;
    logic [7:0] rel8  = '0;
    logic [4:0] req5  = '0;
    logic [4:0] rel5  = '0;
    logic [7:0] g8;
    logic [2:0] no8;
    logic       v8;
    logic       t8;
    logic [4:0] g5;
    logic [2:0] no5;
    logic       v5;
    logic       t5;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    rr_grant_ctrl #(.NUM_ENTRY(N8), .MAX_HOLD(H8)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .I_Req     (req8),
        .I_Release (rel8),
        .O_Grant   (g8),
        .O_GrantNo (no8),
        .O_Valid   (v8),
        .O_Timeout (t8)
    );

    rr_grant_ctrl #(.NUM_ENTRY(N5), .MAX_HOLD(H5)) dut5 (
        .clock     (clock),
        .reset     (reset),
        .I_Req     (req5),
        .I_Release (rel5),
        .O_Grant   (g5),
        .O_GrantNo (no5),
        .O_Valid   (v5),
        .O_Timeout (t5)
    );

    // model: who owns the resource, for how many cycles, turn pointer
    typedef struct {
        int n;
        int maxh;
        int owner;
        int held;
        int ptr;
        int cool;
        bit to;
    } model_t;

    model_t m8;
    model_t m5;

    typedef struct {
        logic [7:0] req;
        logic [7:0] rel;
        logic [7:0] grant;
        logic [2:0] no;
        logic       to;
    } vec_t;

    vec_t tbl[13];

    int got[$];
    int run;
    int pulses;
    logic [7:0] rq8;
    logic [7:0] rl8;
    logic [4:0] rq5;
    logic [4:0] rl5;

    function automatic model_t m_reset(int n, int maxh);
        model_t m;
        m.n     = n;
        m.maxh  = maxh;
        m.owner = -1;
        m.held  = 0;
        m.ptr   = 0;
        m.cool  = 0;
        m.to    = 1'b0;
        return m;
    endfunction

    function automatic model_t m_step(model_t m, logic [7:0] req,
                                      logic [7:0] rel);
        model_t r;
        int     c;
        r    = m;
        r.to = 1'b0;
        if (r.owner >= 0) begin
            if (rel[3'(r.owner)] || !req[3'(r.owner)] ||
                r.held == r.maxh) begin
                r.to    = !rel[3'(r.owner)] && req[3'(r.owner)];
                r.ptr   = (r.owner + 1) % r.n;
                r.owner = -1;
                r.cool  = 1;
            end else begin
                r.held++;
            end
        end else if (r.cool > 0) begin
            r.cool--;
        end else begin
            for (int k = 0; k < r.n; k++) begin
                c = (r.ptr + k) % r.n;
                if (r.owner < 0 && req[3'(c)]) begin
                    r.owner = c;
                    r.held  = 1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [12:0] m_out(model_t m);
        logic [7:0] g;
        logic [2:0] no;
        g  = '0;
        no = '0;
        if (m.owner >= 0) begin
            g[3'(m.owner)] = 1'b1;
            no             = 3'(m.owner);
        end
        return {g, no, (m.owner >= 0), m.to};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // drive, let one rising edge pass, step models, compare both DUTs
    task automatic cycle(logic [7:0] q8, logic [7:0] l8,
                         logic [4:0] q5, logic [4:0] l5);
        req8 = q8;
        rel8 = l8;
        req5 = q5;
        rel5 = l5;
        @(posedge clock);
        m8 = m_step(m8, q8, l8);
        m5 = m_step(m5, {3'b0, q5}, {3'b0, l5});
        #1;
        check("model8", 32'({g8, no8, v8, t8}), 32'(m_out(m8)));
        check("model5", 32'({3'b0, g5, no5, v5, t5}), 32'(m_out(m5)));
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        req8  = '0;
        rel8  = '0;
        req5  = '0;
        rel5  = '0;
        m8    = m_reset(N8, H8);
        m5    = m_reset(N5, H5);
        #1;
        check("rst_async", 32'({g8, no8, v8, t8, g5, no5, v5, t5}), 32'h0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{8'h00, 8'hFF, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{8'h81, 8'h01, 8'h01, 3'd0, 1'b0};
        tbl[3]  = '{8'h81, 8'h80, 8'h01, 3'd0, 1'b0};
        tbl[4]  = '{8'h81, 8'h01, 8'h00, 3'd0, 1'b0};
        tbl[5]  = '{8'h81, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[6]  = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b0};
        tbl[7]  = '{8'h01, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[8]  = '{8'h01, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[9]  = '{8'h01, 8'h00, 8'h01, 3'd0, 1'b0};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[11] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[12] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0};

        // idle after reset
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(8'h00, 8'h00, 5'h00, 5'h00);
        end
        check("idle_out", 32'({g8, no8, v8, t8}), 32'h0);

        // directed table from a fresh reset
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].req, tbl[i].rel, 5'h00, 5'h00);
            check($sformatf("tbl%0d", i), 32'({g8, no8, t8}),
                  32'({tbl[i].grant, tbl[i].no, tbl[i].to}));
        end

        // hold limit: exactly H8 cycles, one pulse, regrant after bubble
        do_reset();
        run    = 0;
        pulses = 0;
        for (int c = 0; c < 10 && g8 != 8'h04; c++) begin
            cycle(8'h04, 8'h00, 5'h00, 5'h00);
        end
        check("t3_start", 32'(g8), 32'h04);
        run = 1;
        for (int c = 0; c < 40; c++) begin
            cycle(8'h04, 8'h00, 5'h00, 5'h00);
            if (t8) pulses++;
            if (g8 != 8'h04) break;
            run++;
        end
        check("t3_len", 32'(run), 32'(H8));
        check("t3_drop", 32'({g8, t8}), 32'h001);
        cycle(8'h04, 8'h00, 5'h00, 5'h00);
        check("t3_bubble", 32'({g8, t8}), 32'h000);
        cycle(8'h04, 8'h00, 5'h00, 5'h00);
        check("t3_regrant", 32'(g8), 32'h04);
        check("t3_pulses", 32'(pulses), 32'd1);

        // all requesting, release every grant cycle: rotation 0..7,0
        do_reset();
        got.delete();
        for (int c = 0; c < 60 && got.size() < 9; c++) begin
            cycle(8'hFF, 8'hFF, 5'h00, 5'h00);
            if (v8) begin
                got.push_back(int'(no8));
                check("t4_match", 32'(g8), 32'(8'(1) << no8));
            end
        end
        check("t4_count", 32'(got.size()), 32'd9);
        for (int i = 0; i < got.size(); i++) begin
            check("t4_order", 32'(got[i]), 32'(i % 8));
        end

        // reset in the middle of a grant, pointer back to 0
        do_reset();
        cycle(8'h02, 8'h00, 5'h00, 5'h00);
        cycle(8'h02, 8'h02, 5'h00, 5'h00);
        cycle(8'h04, 8'h00, 5'h00, 5'h00);
        cycle(8'h04, 8'h00, 5'h00, 5'h00);
        check("t5_grant", 32'(g8), 32'h04);
        for (int c = 0; c < 5; c++) begin
            cycle(8'h04, 8'h00, 5'h00, 5'h00);
        end
        do_reset();
        cycle(8'h06, 8'h00, 5'h00, 5'h00);
        check("t5_after", 32'({g8, no8, t8}), 32'({8'h02, 3'd1, 1'b0}));

        // five entries: wrap from pointer 4, foreign release ignored
        do_reset();
        cycle(8'h00, 8'h00, 5'b01000, 5'b00000);
        check("t6_g3", 32'(g5), 32'b01000);
        cycle(8'h00, 8'h00, 5'b01000, 5'b01000);
        cycle(8'h00, 8'h00, 5'b10001, 5'b00000);
        cycle(8'h00, 8'h00, 5'b10001, 5'b00000);
        check("t6_g4", 32'({g5, no5}), 32'({5'b10000, 3'd4}));
        cycle(8'h00, 8'h00, 5'b10001, 5'b00001);
        check("t6_ignore", 32'({g5, no5}), 32'({5'b10000, 3'd4}));
        cycle(8'h00, 8'h00, 5'b10001, 5'b10000);
        cycle(8'h00, 8'h00, 5'b10001, 5'b00000);
        cycle(8'h00, 8'h00, 5'b10001, 5'b00000);
        check("t6_g0", 32'({g5, no5}), 32'({5'b00001, 3'd0}));

        // random traffic, slowly changing request levels
        do_reset();
        rq8 = '0;
        rq5 = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) rq8 = 8'($urandom);
            if ($urandom_range(0, 11) == 0) rq5 = 5'($urandom);
            rl8 = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
            rl5 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'h00;
            cycle(rq8, rl8, rq5, rl5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
